// File: rtl/alu_x_result_collector.sv
// Result collector for the alu_x pipeline: FWFT result buffer plus issue credits.
// Optional tag sequence check enabled by ALU_X_COLLECTOR_TAG_CHECK_EN.
module alu_x_result_collector #(
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         issue,
    output logic                         credit_ok,
    input  logic                         res_valid,
    input  logic [31:0]                  accumulate,
    input  logic [1:0]                   mode_out,
    input  logic                         operation_out,
    input  logic                         NatLogFlag_iter,
    input  logic [7:0]                   InsTagXOut,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic [1:0]                   out_mode,
    output logic                         out_operation,
    output logic                         out_natlog,
    output logic [7:0]                   out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         proto_err,
    output logic                         tag_error
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  mode;
        logic        op;
        logic        nat;
        logic [7:0]  tag;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          proto_err_q, proto_err_d;
    logic [CW:0]   used;
    logic          full, pop, wr_en, issue_ok, rsp_ok;
    entry_t        head;

    always_comb begin
        used      = {1'b0, inflight_q} + {1'b0, count_q};
        credit_ok = used < (CW+1)'(DEPTH);
        full      = count_q == CW'(DEPTH);
        out_valid = count_q != '0;
        pop       = out_valid & out_ready;
        // A full buffer only takes a new result when the head leaves the same cycle
        wr_en     = res_valid & (~full | pop);
        issue_ok  = issue & credit_ok;
        rsp_ok    = res_valid & (inflight_q != '0);

        inflight_d = inflight_q;
        if (issue_ok && !rsp_ok)
            inflight_d = inflight_q + CW'(1);
        else if (!issue_ok && rsp_ok)
            inflight_d = inflight_q - CW'(1);

        count_d = count_q;
        if (wr_en && !pop)
            count_d = count_q + CW'(1);
        else if (!wr_en && pop)
            count_d = count_q - CW'(1);

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        proto_err_d = proto_err_q
                    | (issue & ~credit_ok)
                    | (res_valid & (inflight_q == '0))
                    | (res_valid & full & ~pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            inflight_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= '{accumulate, mode_out, operation_out,
                                 NatLogFlag_iter, InsTagXOut};
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        out_data      = head.data;
        out_mode      = head.mode;
        out_operation = head.op;
        out_natlog    = head.nat;
        out_tag       = head.tag;
        count         = count_q;
        proto_err     = proto_err_q;
    end

`ifdef ALU_X_COLLECTOR_TAG_CHECK_EN
    logic [7:0] expected_tag_q, expected_tag_d;
    logic       tag_error_q, tag_error_d;

    // Resync to the observed tag so one gap raises a single error
    always_comb begin
        expected_tag_d = wr_en ? InsTagXOut + 8'd1 : expected_tag_q;
        tag_error_d    = tag_error_q
                       | (wr_en & (InsTagXOut != expected_tag_q));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            expected_tag_q <= 8'h00;
            tag_error_q    <= 1'b0;
        end else begin
            expected_tag_q <= expected_tag_d;
            tag_error_q    <= tag_error_d;
        end
    end

    assign tag_error = tag_error_q;
`else
    assign tag_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_x_result_collector.sv
// Directed self-checking bench for alu_x_result_collector.
module tb_alu_x_result_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue, credit_ok, res_valid;
    logic [31:0] accumulate;
    logic [1:0]  mode_out;
    logic        operation_out, NatLogFlag_iter;
    logic [7:0]  InsTagXOut;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic        out_operation, out_natlog;
    logic [7:0]  out_tag;
    logic [4:0]  count;
    logic        proto_err, tag_error;

    int n_tests = 0;
    int n_fail  = 0;

    alu_x_result_collector #(.DEPTH(16)) dut (
        .clock(clock), .reset(reset), .issue(issue), .credit_ok(credit_ok),
        .res_valid(res_valid), .accumulate(accumulate), .mode_out(mode_out),
        .operation_out(operation_out), .NatLogFlag_iter(NatLogFlag_iter),
        .InsTagXOut(InsTagXOut), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mode(out_mode), .out_operation(out_operation),
        .out_natlog(out_natlog), .out_tag(out_tag), .count(count),
        .proto_err(proto_err), .tag_error(tag_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue = 0; res_valid = 0; out_ready = 0;
        accumulate = '0; mode_out = '0; operation_out = 0;
        NatLogFlag_iter = 0; InsTagXOut = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        step();
        reset = 1;
        step();
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] t, input logic rdy);
        res_valid = 1; accumulate = d; InsTagXOut = t; out_ready = rdy;
        step();
        res_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        issue = 1; res_valid = 1; out_ready = 1;
        accumulate = 32'hFFFF_FFFF; InsTagXOut = 8'h55;
        repeat (3) step();
        n_tests++;
        if (count !== 5'd0 || out_valid !== 1'b0 || credit_ok !== 1'b1 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: count=%0d valid=%b credit=%b perr=%b, want 0 0 1 0",
                     count, out_valid, credit_ok, proto_err);
        end
        idle_inputs();
        reset = 1;
        repeat (5) step();
        n_tests++;
        if (count !== 5'd0 || out_valid !== 1'b0 || credit_ok !== 1'b1 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: count=%0d valid=%b credit=%b perr=%b, want 0 0 1 0",
                     count, out_valid, credit_ok, proto_err);
        end
    endtask

    task automatic test_credit();
        do_reset();
        issue = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 14) begin
                n_tests++;
                if (credit_ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL credit_15: credit_ok=%b want 1", credit_ok);
                end
            end
        end
        n_tests++;
        if (credit_ok !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_16: credit_ok=%b perr=%b want 0 0", credit_ok, proto_err);
        end
        step();
        issue = 0;
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_17_perr: proto_err=%b want 1", proto_err);
        end
        for (int i = 0; i < 16; i++)
            push(32'(i), 8'(i), 1'b0);
        n_tests++;
        if (count !== 5'd16 || credit_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_ret: count=%0d credit=%b want 16 0", count, credit_ok);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        n_tests++;
        if (count !== 5'd15 || credit_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_inflight: count=%0d credit=%b want 15 1", count, credit_ok);
        end
    endtask

    task automatic test_order();
        logic [7:0] t;
        do_reset();
        issue = 1;
        repeat (8) step();
        issue = 0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_pre: out_valid=%b want 0", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            t = 8'(i);
            res_valid = 1; out_ready = 1;
            accumulate = 32'h3F80_0000 + 32'(i); InsTagXOut = t;
            mode_out = t[1:0]; operation_out = t[0]; NatLogFlag_iter = t[1];
            step();
            n_tests++;
            if (out_valid !== 1'b1 || count !== 5'd1 || out_data !== 32'h3F80_0000 + 32'(i)
                || out_tag !== t || out_mode !== t[1:0] || out_operation !== t[0]
                || out_natlog !== t[1]) begin
                n_fail++;
                $display("FAIL order_%0d: v=%b cnt=%0d data=%h tag=%h mode=%0d op=%b nl=%b, want 1 1 %h %h %0d %b %b",
                         i, out_valid, count, out_data, out_tag, out_mode, out_operation,
                         out_natlog, 32'h3F80_0000 + 32'(i), t, t[1:0], t[0], t[1]);
            end
        end
        res_valid = 0;
        step();
        out_ready = 0;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 5'd0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL order_end: v=%b cnt=%0d perr=%b want 0 0 0", out_valid, count, proto_err);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_q [$];
        do_reset();
        issue = 1;
        repeat (16) step();
        issue = 0;
        for (int i = 0; i < 16; i++)
            push(32'hA000_0000 + 32'(i), 8'(i), 1'b0);
        n_tests++;
        if (count !== 5'd16 || proto_err !== 1'b0 || credit_ok !== 1'b0 || out_data !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL full_fill: cnt=%0d perr=%b credit=%b data=%h want 16 0 0 a0000000",
                     count, proto_err, credit_ok, out_data);
        end
        push(32'hB000_0000, 8'h10, 1'b1);
        n_tests++;
        if (count !== 5'd16 || out_data !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL full_pushpop: cnt=%0d data=%h want 16 a0000001", count, out_data);
        end
        push(32'hC000_0000, 8'h11, 1'b0);
        n_tests++;
        if (count !== 5'd16 || proto_err !== 1'b1 || out_data !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL full_drop: cnt=%0d perr=%b data=%h want 16 1 a0000001",
                     count, proto_err, out_data);
        end
        for (int i = 1; i < 16; i++)
            exp_q.push_back(32'hA000_0000 + 32'(i));
        exp_q.push_back(32'hB000_0000);
        out_ready = 1;
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin
                n_fail++;
                $display("FAIL full_drain_%0d: v=%b data=%h want 1 %h", k, out_valid, out_data, exp_q[k]);
            end
            step();
        end
        out_ready = 0;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL full_empty: v=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_tag();
        logic [7:0] tags [4];
        logic       exp_err [4];
        tags = '{8'd0, 8'd1, 8'd3, 8'd4};
`ifdef ALU_X_COLLECTOR_TAG_CHECK_EN
        exp_err = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        issue = 1;
        repeat (4) step();
        issue = 0;
        for (int i = 0; i < 4; i++) begin
            push(32'h1234_0000 + 32'(i), tags[i], 1'b1);
            n_tests++;
            if (tag_error !== exp_err[i]) begin
                n_fail++;
                $display("FAIL tag_%0d: tag_error=%b want %b", i, tag_error, exp_err[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue = 1;
        repeat (8) step();
        issue = 0;
        for (int i = 0; i < 5; i++)
            push(32'hD000_0000 + 32'(i), 8'(i), 1'b0);
        n_tests++;
        if (count !== 5'd5 || credit_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: cnt=%0d credit=%b want 5 1", count, credit_ok);
        end
        #2 reset = 0;
        #1;
        n_tests++;
        if (count !== 5'd0 || credit_ok !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: cnt=%0d credit=%b v=%b want 0 1 0", count, credit_ok, out_valid);
        end
        step();
        reset = 1;
        for (int i = 5; i < 8; i++)
            push(32'hE000_0000 + 32'(i), 8'(i), 1'b0);
        n_tests++;
        if (count !== 5'd3) begin
            n_fail++;
            $display("FAIL mid_late_cnt: cnt=%0d want 3", count);
        end
        out_ready = 1;
        for (int i = 5; i < 8; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hE000_0000 + 32'(i) || out_tag !== 8'(i)) begin
                n_fail++;
                $display("FAIL mid_late_%0d: v=%b data=%h tag=%h want 1 %h %h",
                         i, out_valid, out_data, out_tag, 32'hE000_0000 + 32'(i), 8'(i));
            end
            step();
        end
        out_ready = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_credit();
        test_order();
        test_full();
        test_tag();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
